// File: rtl/wb_spi_slave_if.sv
// ----------------------------------------------------------------------------
// wb_spi_slave_if
//   Wishbone bus bundle for the SPI slave peripheral.
//   Signal names keep the peripheral-side view (_i driven by the master,
//   _o driven by the slave).
//   wb_adr_i  [31:0]  word address, only [3:2] decoded by the slave
//   wb_dat_i  [31:0]  write data
//   wb_dat_o  [31:0]  read data
//   wb_sel_i  [3:0]   byte selects
//   wb_stb_i, wb_cyc_i, wb_we_i   strobe / cycle / write enable
//   wb_ack_o          acknowledge
// ----------------------------------------------------------------------------
interface wb_spi_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_spi_slave.sv
// ----------------------------------------------------------------------------
// wb_spi_slave
//   Wishbone-attached SPI target (mode 0, MSB first, 8-bit frames).
//   An external master shifts bytes in on spi_mosi and out on spi_miso; the
//   CPU drains received bytes and queues transmit bytes through four
//   word-aligned registers (RXDATA, TXDATA, STATUS, CTRL).
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   wb             Wishbone slave modport (see wb_spi_slave_if)
//   spi_sck        SPI clock from the external master (asynchronous)
//   spi_cs_n       chip select, active low (asynchronous)
//   spi_mosi       serial data in
//   spi_miso       serial data out, idles high while not selected
//   intr           level interrupt, active high
// ----------------------------------------------------------------------------
module wb_spi_slave #(
  parameter int          sync_stages = 2,
  parameter logic [7:0]  idle_byte   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  wb_spi_slave_if.slave     wb,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              intr
);

  // Fewer than two stages would not be a synchroniser at all.
  localparam int Stages = (sync_stages < 2) ? 2 : sync_stages;

  // Synchroniser chains plus a "primed" chain that tells us when the
  // synchronised pins reflect real pin values rather than reset fill.
  logic [Stages-1:0] sckSync_q, csSync_q, mosiSync_q, primeSync_q;
  logic              sckDly_q, csDly_q;
  logic              armed_q, armed_d;

  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic [7:0]  txShift_q, txShift_d;
  logic [7:0]  rxBuf_q, rxBuf_d;
  logic [7:0]  txBuf_q, txBuf_d;
  logic        rxFull_q, rxFull_d;
  logic        txFull_q, txFull_d;
  logic        overrun_q, overrun_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        ack_q, ack_d;
  logic [31:0] datO_q, datO_d;
  logic        intr_q, intr_d;

  logic        sckS, csS, mosiS, syncValid;
  logic        sckRise, sckFall, csFall, active;
  logic        wbReq, wbWrite, wbRead;
  logic        rxRead, txWrite, statusWrite, ctrlWrite;
  logic        byteDone, txReload;
  logic [7:0]  newByte;
  logic [31:0] rdData;
  logic        unusedBits;

  assign sckS      = sckSync_q[Stages-1];
  assign csS       = csSync_q[Stages-1];
  assign mosiS     = mosiSync_q[Stages-1];
  assign syncValid = primeSync_q[Stages-1];

  // A transfer only counts once chip select has been seen high after reset,
  // so a frame already in progress when reset released is ignored.
  assign active  = armed_q & ~csS;
  assign csFall  = armed_q & csDly_q & ~csS;
  assign sckRise = sckS & ~sckDly_q;
  assign sckFall = ~sckS & sckDly_q;

  assign wbReq       = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wbWrite     = wbReq & wb.wb_we_i;
  assign wbRead      = wbReq & ~wb.wb_we_i;
  assign rxRead      = wbRead  & (wb.wb_adr_i[3:2] == 2'd0);
  assign txWrite     = wbWrite & (wb.wb_adr_i[3:2] == 2'd1);
  assign statusWrite = wbWrite & (wb.wb_adr_i[3:2] == 2'd2);
  assign ctrlWrite   = wbWrite & (wb.wb_adr_i[3:2] == 2'd3);

  assign newByte  = {rxShift_q[6:0], mosiS};
  assign byteDone = active & ~csFall & sckRise & (bitCnt_q == 3'd7);
  assign txReload = csFall | (active & sckFall & (bitCnt_q == 3'd0));

  assign spi_miso    = active ? txShift_q[7] : 1'b1;
  assign intr        = intr_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = datO_q;

  // Byte selects and undecoded address/data bits are intentionally ignored.
  assign unusedBits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                        wb.wb_dat_i[31:8]};

  // Read multiplexer; sampled into datO_q on the request edge so a read
  // always returns the register contents from before that edge's updates.
  always_comb begin
    rdData = 32'h0;
    case (wb.wb_adr_i[3:2])
      2'd0:    rdData = {24'h0, rxBuf_q};
      2'd1:    rdData = 32'h0;
      2'd2:    rdData = {28'h0, ~csS, overrun_q, txFull_q, rxFull_q};
      default: rdData = {30'h0, ctrl_q};
    endcase
  end

  // Next-state logic for the shifters, buffers and flags. Ordering inside
  // the block sets priority: a TX write lands after a reload that consumed
  // the old buffer, and an overrun set beats a software clear.
  always_comb begin
    armed_d   = armed_q | (syncValid & csS);
    bitCnt_d  = bitCnt_q;
    rxShift_d = rxShift_q;
    txShift_d = txShift_q;
    rxBuf_d   = rxBuf_q;
    txBuf_d   = txBuf_q;
    rxFull_d  = rxFull_q;
    txFull_d  = txFull_q;
    overrun_d = overrun_q;
    ctrl_d    = ctrl_q;

    if (!active) begin
      bitCnt_d = 3'd0;
    end else if (csFall) begin
      bitCnt_d  = 3'd0;
      rxShift_d = 8'h00;
    end else if (sckRise) begin
      rxShift_d = newByte;
      bitCnt_d  = bitCnt_q + 3'd1;
    end

    if (txReload) begin
      txShift_d = txFull_q ? txBuf_q : idle_byte;
      txFull_d  = 1'b0;
    end else if (active && sckFall) begin
      txShift_d = {txShift_q[6:0], 1'b0};
    end

    if (byteDone) begin
      // A read in the same cycle frees the buffer, so no byte is lost.
      if (!rxFull_q || rxRead) begin
        rxBuf_d  = newByte;
        rxFull_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rxRead) begin
      rxFull_d = 1'b0;
    end

    if (statusWrite && wb.wb_dat_i[2] && !(byteDone && rxFull_q && !rxRead)) begin
      overrun_d = 1'b0;
    end

    if (txWrite) begin
      txBuf_d  = wb.wb_dat_i[7:0];
      txFull_d = 1'b1;
    end

    if (ctrlWrite) begin
      ctrl_d = wb.wb_dat_i[1:0];
    end
  end

  // Bus handshake outputs and the interrupt are registered.
  always_comb begin
    ack_d  = wbReq;
    datO_d = wbRead ? rdData : 32'h0;
    intr_d = (ctrl_q[0] & rxFull_q) | (ctrl_q[1] & ~txFull_q);
  end

  // All state updates on the rising edge with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sckSync_q   <= '0;
      csSync_q    <= '1;
      mosiSync_q  <= '0;
      primeSync_q <= '0;
      sckDly_q    <= 1'b0;
      csDly_q     <= 1'b1;
      armed_q     <= 1'b0;
      bitCnt_q    <= 3'd0;
      rxShift_q   <= 8'h00;
      txShift_q   <= 8'h00;
      rxBuf_q     <= 8'h00;
      txBuf_q     <= 8'h00;
      rxFull_q    <= 1'b0;
      txFull_q    <= 1'b0;
      overrun_q   <= 1'b0;
      ctrl_q      <= 2'b00;
      ack_q       <= 1'b0;
      datO_q      <= 32'h0;
      intr_q      <= 1'b0;
    end else begin
      sckSync_q   <= {sckSync_q[Stages-2:0], spi_sck};
      csSync_q    <= {csSync_q[Stages-2:0], spi_cs_n};
      mosiSync_q  <= {mosiSync_q[Stages-2:0], spi_mosi};
      primeSync_q <= {primeSync_q[Stages-2:0], 1'b1};
      sckDly_q    <= sckS;
      csDly_q     <= csS;
      armed_q     <= armed_d;
      bitCnt_q    <= bitCnt_d;
      rxShift_q   <= rxShift_d;
      txShift_q   <= txShift_d;
      rxBuf_q     <= rxBuf_d;
      txBuf_q     <= txBuf_d;
      rxFull_q    <= rxFull_d;
      txFull_q    <= txFull_d;
      overrun_q   <= overrun_d;
      ctrl_q      <= ctrl_d;
      ack_q       <= ack_d;
      datO_q      <= datO_d;
      intr_q      <= intr_d;
    end
  end

endmodule

// File: doc/wb_spi_slave.md
Name: wb_spi_slave

Overview:
Wishbone-attached SPI slave (target) peripheral. An external SPI master clocks bytes in on spi_mosi and out on spi_miso. The CPU drains received bytes and queues transmit bytes through four word-aligned registers. It is the counterpart of wb_spi and occupies a conbus slave slot like the other peripherals; intr feeds one intr_n bit (inverted at system level).

Parameters:
sync_stages, 2, flip-flop depth of the synchronisers on spi_sck, spi_cs_n and spi_mosi (minimum 2).
idle_byte, 8'hFF, byte shifted out when no TX byte is queued (underrun).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous reset, active-high.
wb_adr_i  input  32  Wishbone address; only [3:2] decoded.
wb_dat_i  input  32  Wishbone write data.
wb_dat_o  output  32  Wishbone read data, registered.
wb_stb_i  input  1  Wishbone strobe.
wb_cyc_i  input  1  Wishbone cycle.
wb_we_i  input  1  Wishbone write enable.
wb_sel_i  input  4  byte selects; ignored, full-word access.
wb_ack_o  output  1  Wishbone acknowledge.
spi_sck  input  1  SPI clock from the external master, asynchronous.
spi_cs_n  input  1  chip select, active-low, asynchronous.
spi_mosi  input  1  serial data in.
spi_miso  output  1  serial data out.
intr  output  1  level interrupt, active-high.

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous and active-high.
- Reset values: wb_ack_o=0, wb_dat_o=0, spi_miso=1, intr=0. All registers and flags are 0. The sck synchroniser chain loads 0; the cs_n chain loads 1.
- Wishbone access:
  - stb&cyc&~ack gives wb_ack_o=1 on the next clk, for exactly one cycle.
  - Ack is forced low in the cycle after an ack, so there is always one wait state.
  - The register side effect happens in the ack cycle.
- Register map (wb_adr_i[3:2]):
  - 0 RXDATA (R): [7:0] rx_buf, upper bits 0. A read clears rx_full.
  - 1 TXDATA (W): [7:0] loads tx_buf and sets tx_full. Reads return 0.
  - 2 STATUS: bit0 rx_full, bit1 tx_full, bit2 overrun, bit3 busy (synchronised cs_n low). Writing 1 to bit2 clears overrun; other bits are read-only.
  - 3 CTRL (R/W): bit0 rx_irq_en, bit1 tx_irq_en.
- SPI protocol: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, any number of bytes per CS assertion.
- Synchronisation and edge detection: rise/fall of synced sck and fall/rise of synced cs_n come from a one-cycle delay register. spi_sck must be ≤ clk/8.
- CS assert (synced cs_n 1→0):
  - bit_cnt=0, rx shift register cleared.
  - tx_shift = tx_buf if tx_full, else idle_byte; tx_full cleared.
- While CS is active:
  - spi_miso = tx_shift[7].
  - sck rising edge: rx_shift = {rx_shift[6:0], mosi_sync}; bit_cnt increments mod 8.
  - When the 8th rise wraps bit_cnt to 0:
    - Byte complete.
    - If rx_full=0: rx_buf=new byte and rx_full=1, in the same cycle as the edge detect.
    - If rx_full=1: byte dropped, rx_buf unchanged, overrun=1.
  - sck falling edge with bit_cnt≠0: tx_shift shifts left by 1.
  - sck falling edge with bit_cnt=0 (byte boundary): tx_shift reloads from tx_buf or idle_byte, clearing tx_full.
- CS deassert: at any bit_cnt, the partial byte is discarded (rx_full unchanged) and bit_cnt=0. spi_miso=1 while CS is inactive.
- Simultaneous events:
  - RXDATA read in the same cycle as byte completion with rx_full=1: the read returns the old byte, the new byte is stored, rx_full stays 1, and no overrun is flagged.
  - TXDATA write in the same cycle as a tx reload: the reload uses the old tx_buf (or idle_byte if tx_full=0); the new write then sets tx_buf and tx_full=1.
  - Overrun set and clear in the same cycle: set wins.
- intr = (rx_irq_en & rx_full) | (tx_irq_en & ~tx_full), registered (one cycle latency).
- Reset asserted mid-transfer returns everything to reset values. Any transfer whose CS was already low when reset released is ignored until cs_n goes high and then low again.

Test Plan:
- Reset → spi_miso=1, intr=0; STATUS reads 0x0, CTRL reads 0x0; wb_ack_o is a single-cycle pulse per access.
- Write TXDATA=0xA5, then master sends 0x3C with CS low, sck=clk/8 → miso bits 1,0,1,0,0,1,0,1; RXDATA=0x3C; STATUS: rx_full=1, tx_full=0.
- Two-byte burst under one CS with no TX queued (MOSI 0x12 then 0x34) → miso=0xFF,0xFF. First byte 0x12 is captured; the second is dropped and overrun=1. After reading RXDATA=0x12, write STATUS=0x4 → overrun=0.
- CS deasserted after 5 sck rises → rx_full stays 0. A following full byte 0x81 is received correctly (bit_cnt was restarted).
- CTRL=0x1, receive byte 0x55 → intr=1. Read RXDATA (0x55) → intr=0 within 2 cycles. Then CTRL=0x2 with tx empty → intr=1; write TXDATA → intr=0.
- Assert reset between sck rises 3 and 4 with CS still low → all flags clear. Bytes ignored until CS high→low; the next frame 0xC3 is received correctly.
